// File: rtl/sensor_freq_generator.sv
// Fractional-accumulator square-wave generator emulating the colour sensor's frequency output.
// Optional burst mode (fixed count of rising edges) is enabled by defining SENSOR_GEN_BURST_EN.
module sensor_freq_generator #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DEFAULT_FREQ = 0,
    parameter int unsigned FREQ_W       = 21
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              gen_on,
    input  logic              freq_load,
    input  logic [FREQ_W-1:0] freq_value,
`ifdef SENSOR_GEN_BURST_EN
    input  logic [15:0]       burst_len,
    output logic              burst_done,
`endif
    output logic [FREQ_W-1:0] freq_active,
    output logic              wave_out,
    output logic              rise_strobe
);

    localparam int unsigned       AccW        = 28;
    localparam int unsigned       HalfHz      = CLK_HZ / 2;
    localparam logic [AccW-1:0]   ClkHz       = AccW'(CLK_HZ);
    localparam logic [FREQ_W-1:0] DefaultFreq = FREQ_W'(DEFAULT_FREQ);
    // Only selected when freq_value exceeds HalfHz, so it always fits in FREQ_W bits.
    localparam logic [FREQ_W-1:0] HalfFreq    = FREQ_W'(HalfHz);

    typedef enum logic [1:0] {
        StIdle,
        StRun
`ifdef SENSOR_GEN_BURST_EN
        ,
        StBurstDone
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic              wave_q, wave_d;
    logic              rise_q, rise_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [AccW-1:0]   sum;
    logic              toggle;
    logic [FREQ_W-1:0] freq_clamped;
`ifdef SENSOR_GEN_BURST_EN
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
`endif

    always_comb begin
        freq_clamped = (32'(freq_value) > HalfHz) ? HalfFreq : freq_value;
        // acc < CLK_HZ and 2*f <= CLK_HZ, so sum < 2*CLK_HZ fits in AccW bits.
        sum          = acc_q + (AccW'(freq_q) << 1);
        toggle       = (sum >= ClkHz);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wave_d  = wave_q;
        rise_d  = 1'b0;
        freq_d  = freq_load ? freq_clamped : freq_q;
`ifdef SENSOR_GEN_BURST_EN
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`endif
        case (state_q)
            StIdle: begin
                acc_d  = '0;
                wave_d = 1'b0;
`ifdef SENSOR_GEN_BURST_EN
                cnt_d  = '0;
                done_d = 1'b0;
                if (gen_on) len_d = burst_len;
`endif
                if (gen_on) state_d = StRun;
            end
            StRun: begin
                if (!gen_on) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    wave_d  = 1'b0;
                end else begin
                    acc_d = toggle ? (sum - ClkHz) : sum;
                    if (toggle) begin
                        wave_d = ~wave_q;
                        rise_d = ~wave_q;
`ifdef SENSOR_GEN_BURST_EN
                        // The falling toggle after the last requested rise ends the burst.
                        if (!wave_q) begin
                            cnt_d = cnt_q + 16'd1;
                        end else if ((len_q != 16'd0) && (cnt_q == len_q)) begin
                            state_d = StBurstDone;
                            done_d  = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef SENSOR_GEN_BURST_EN
            StBurstDone: begin
                acc_d  = '0;
                wave_d = 1'b0;
                if (!gen_on) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            freq_q  <= DefaultFreq;
`ifdef SENSOR_GEN_BURST_EN
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wave_q  <= wave_d;
            rise_q  <= rise_d;
            freq_q  <= freq_d;
`ifdef SENSOR_GEN_BURST_EN
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`endif
        end
    end

    assign freq_active = freq_q;
    assign wave_out    = wave_q;
    assign rise_strobe = rise_q;
`ifdef SENSOR_GEN_BURST_EN
    assign burst_done  = done_q;
`endif

endmodule

// File: tb/tb_sensor_freq_generator.sv
// Bench for sensor_freq_generator with CLK_HZ scaled to 100: directed vector table,
// hand-written corner sequences, and random stimulus against a phase-based reference model.
module tb_sensor_freq_generator;

    localparam int unsigned ClkHz = 100;
    localparam int unsigned FreqW = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             gen_on;
    logic             freq_load;
    logic [FreqW-1:0] freq_value;
    logic [FreqW-1:0] freq_active;
    logic             wave_out;
    logic             rise_strobe;

    sensor_freq_generator #(
        .CLK_HZ      (ClkHz),
        .DEFAULT_FREQ(0),
        .FREQ_W      (FreqW)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .gen_on     (gen_on),
        .freq_load  (freq_load),
        .freq_value (freq_value),
        .freq_active(freq_active),
        .wave_out   (wave_out),
        .rise_strobe(rise_strobe)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: total phase P accumulated while running; wave level = parity of floor(P/CLK).
    bit              m_run;
    longint unsigned m_phase;
    int unsigned     m_fact;
    bit              m_wave;
    bit              m_rise;

    typedef struct {
        bit          g;
        bit          l;
        int unsigned v;
        bit          ew;
        bit          er;
        int unsigned ef;
    } vec_t;

    vec_t vecs[16];

    function automatic int unsigned clamp(input int unsigned v);
        return (v > ClkHz / 2) ? ClkHz / 2 : v;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_phase = 0;
        m_fact  = 0;
        m_wave  = 1'b0;
        m_rise  = 1'b0;
    endtask

    task automatic model_step(input bit g, input bit l, input int unsigned v);
        bit prev;
        prev   = m_wave;
        m_rise = 1'b0;
        if (m_run && g) begin
            m_phase = m_phase + 2 * longint'(m_fact);
            m_wave  = ((m_phase / ClkHz) % 2) == 1;
            m_rise  = m_wave && !prev;
        end else begin
            m_phase = 0;
            m_wave  = 1'b0;
            m_run   = g;
        end
        if (l) m_fact = clamp(v);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, clock once, compare against the model at the following negedge.
    task automatic cycle(input bit g, input bit l, input int unsigned v);
        gen_on     = g;
        freq_load  = l;
        freq_value = FreqW'(v);
        @(posedge clk);
        model_step(g, l, v);
        @(negedge clk);
        freq_load = 1'b0;
        check("model_wave", longint'(wave_out), longint'(m_wave));
        check("model_rise", longint'(rise_strobe), longint'(m_rise));
        check("model_fact", longint'(freq_active), longint'(m_fact));
    endtask

    initial begin
        int rises;
        vecs[0]  = '{0, 1, 25, 0, 0, 25};
        vecs[1]  = '{1, 0, 0, 0, 0, 25};
        vecs[2]  = '{1, 0, 0, 0, 0, 25};
        vecs[3]  = '{1, 0, 0, 1, 1, 25};
        vecs[4]  = '{1, 0, 0, 1, 0, 25};
        vecs[5]  = '{1, 0, 0, 0, 0, 25};
        vecs[6]  = '{1, 0, 0, 0, 0, 25};
        vecs[7]  = '{1, 0, 0, 1, 1, 25};
        vecs[8]  = '{1, 1, 60, 1, 0, 50};
        vecs[9]  = '{1, 0, 0, 0, 0, 50};
        vecs[10] = '{1, 0, 0, 1, 1, 50};
        vecs[11] = '{0, 1, 12, 0, 0, 12};
        vecs[12] = '{0, 0, 0, 0, 0, 12};
        vecs[13] = '{0, 1, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 0};

        rst        = 1'b1;
        gen_on     = 1'b0;
        freq_load  = 1'b0;
        freq_value = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_wave", longint'(wave_out), 0);
        check("reset_rise", longint'(rise_strobe), 0);
        check("reset_fact", longint'(freq_active), 0);
        rst = 1'b0;

        // Directed table: 25 Hz period 4, clamp 60->50, load with gen_on falling, f=0 frozen.
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].g, vecs[i].l, vecs[i].v);
            check($sformatf("vec%0d_wave", i), longint'(wave_out), longint'(vecs[i].ew));
            check($sformatf("vec%0d_rise", i), longint'(rise_strobe), longint'(vecs[i].er));
            check($sformatf("vec%0d_fact", i), longint'(freq_active), longint'(vecs[i].ef));
        end
        cycle(0, 0, 0);

        // f=3 at CLK_HZ=100: 300 running cycles give 9 rises.
        cycle(0, 1, 3);
        cycle(1, 0, 0);
        rises = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1, 0, 0);
            if (rise_strobe) rises++;
        end
        check("f3_rises_300", longint'(rises), 9);
        cycle(0, 0, 0);

        // Asynchronous reset while wave_out is high clears outputs without a clock edge.
        cycle(0, 1, 25);
        cycle(1, 0, 0);
        for (int i = 0; i < 10 && !wave_out; i++) cycle(1, 0, 0);
        check("pre_reset_high", longint'(wave_out), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_wave", longint'(wave_out), 0);
        check("async_reset_rise", longint'(rise_strobe), 0);
        check("async_reset_fact", longint'(freq_active), 0);
        gen_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random stimulus: mostly running, occasional reloads (including out-of-range values).
        for (int i = 0; i < 3000; i++) begin
            bit          g;
            bit          l;
            int unsigned v;
            g = ($urandom_range(0, 24) != 0);
            l = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2097151) : $urandom_range(0, 60);
            cycle(g, l, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
